// File: rtl/fir_pkg.sv
// Shared widths, FSM state and tag type for the 6-tap FIR tap scheduler.
package fir_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 14;
  localparam int unsigned NTAPS     = 6;
  localparam int unsigned OUT_W     = 26;
  localparam int unsigned LAT       = 2;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DRAIN_CYC = NTAPS - 1;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned BANK_W    = NTAPS * COEF_W;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Per-cycle qualifier travelling alongside the sample through the filter.
  typedef struct packed {
    logic vld;
    logic tail;
  } tag_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks.
//   wr_en/wr_addr/wr_data : shadow write (already qualified by the caller)
//   copy                  : active <= shadow (sees a same-cycle write)
//   addr_err_c            : write addressed a non-existent tap
//   fir_coef              : flattened active bank, tap k at [k*COEF_W +: COEF_W]
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              copy,
  output logic              addr_err_c,
  output logic [BANK_W-1:0] fir_coef
);

  logic [NTAPS-1:0][COEF_W-1:0] shadow_q, shadow_d;
  logic [NTAPS-1:0][COEF_W-1:0] active_q, active_d;

  assign addr_err_c = wr_en && (wr_addr >= ADDR_W'(NTAPS));

  // Write lands in the shadow first so a same-cycle copy picks it up.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    for (int k = 0; k < NTAPS; k++) begin
      if (wr_en && (wr_addr == ADDR_W'(k))) shadow_d[k] = wr_data;
    end
    if (copy) active_d = shadow_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign fir_coef = active_q;

endmodule

// File: rtl/fir_tap_sched.sv
// Sequencer for a free-running 6-tap transposed FIR.
//   in_*        : sample valid/ready handshake; fir_a carries the sample (0 when idle/draining)
//   coef_*      : shadow-bank programming and commit (swap_mode 0 = immediate, 1 = drain)
//   fir_coef    : active coefficient bank to the filter
//   out_valid/out_tail : qualifiers aligned with filter output b
//   busy/underrun/wr_err : status (underrun and wr_err are sticky)
module fir_tap_sched
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              coef_wr_en,
  input  logic [ADDR_W-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0] coef_wr_data,
  input  logic              coef_commit,
  input  logic              swap_mode,
  output logic [DATA_W-1:0] fir_a,
  output logic [BANK_W-1:0] fir_coef,
  output logic              out_valid,
  output logic              out_tail,
  output logic              busy,
  output logic              underrun,
  output logic              wr_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               wr_err_q, wr_err_d;
  tag_t [LAT-1:0]     tag_q, tag_d;

  logic fire;
  logic wr_go;
  logic commit_go;
  logic bank_copy;
  logic bank_addr_err_c;

  // in_ready is a flop so it stays low through reset and rises one cycle after release.
  assign fire      = in_valid && in_ready_q;
  assign fir_a     = fire ? in_data : '0;
  assign wr_go     = coef_wr_en && !busy_q;
  assign commit_go = coef_commit && !busy_q;

  fir_coef_bank u_bank (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_go),
    .wr_addr    (coef_wr_addr),
    .wr_data    (coef_wr_data),
    .copy       (bank_copy),
    .addr_err_c (bank_addr_err_c),
    .fir_coef   (fir_coef)
  );

  // Next-state, bank-swap control, status and tag pipeline.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    underrun_d = underrun_q;
    wr_err_d   = wr_err_q;
    bank_copy  = 1'b0;
    tag_d      = {tag_q[LAT-2:0], tag_t'{vld: fire, tail: (state_q == ST_DRAIN)}};

    if (in_ready_q && !in_valid) underrun_d = 1'b1;
    if (busy_q && (coef_wr_en || coef_commit)) wr_err_d = 1'b1;
    if (bank_addr_err_c) wr_err_d = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (commit_go) begin
          busy_d = 1'b1;
          if (swap_mode) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYC);
          end else begin
            bank_copy = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        // Zeros have flushed every old-sample term; swap on the last drain cycle.
        if (cnt_q == CNT_W'(1)) begin
          bank_copy = 1'b1;
          state_d   = ST_RUN;
          busy_d    = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    in_ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      wr_err_q   <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      wr_err_q   <= wr_err_d;
      tag_q      <= tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;
  assign wr_err    = wr_err_q;
  assign out_valid = tag_q[LAT-1].vld;
  assign out_tail  = tag_q[LAT-1].tail;

endmodule

// File: tb/tb_fir_tap_sched.sv
// Directed bench for fir_tap_sched with a behavioural transposed FIR attached
// (input register captures sample and coefficients together, registered b).
module tb_fir_tap_sched;
  import fir_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              coef_wr_en;
  logic [ADDR_W-1:0] coef_wr_addr;
  logic [COEF_W-1:0] coef_wr_data;
  logic              coef_commit;
  logic              swap_mode;
  logic [DATA_W-1:0] fir_a;
  logic [BANK_W-1:0] fir_coef;
  logic              out_valid;
  logic              out_tail;
  logic              busy;
  logic              underrun;
  logic              wr_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fir_tap_sched dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_commit  (coef_commit),
    .swap_mode    (swap_mode),
    .fir_a        (fir_a),
    .fir_coef     (fir_coef),
    .out_valid    (out_valid),
    .out_tail     (out_tail),
    .busy         (busy),
    .underrun     (underrun),
    .wr_err       (wr_err)
  );

  // Filter model.
  logic [DATA_W-1:0] x_q = '0;
  logic [BANK_W-1:0] c_q = '0;
  logic [OUT_W-1:0]  z [1:NTAPS-1];
  logic [OUT_W-1:0]  b = '0;

  initial for (int k = 1; k < NTAPS; k++) z[k] = '0;

  function automatic logic [OUT_W-1:0] tp(input int k);
    return OUT_W'(x_q) * OUT_W'(c_q[k*COEF_W +: COEF_W]);
  endfunction

  always @(posedge clk) begin
    x_q <= fir_a;
    c_q <= fir_coef;
    b   <= tp(0) + z[1];
    for (int k = 1; k < NTAPS - 1; k++) z[k] <= tp(k) + z[k+1];
    z[NTAPS-1] <= tp(NTAPS - 1);
  end

  function automatic logic [BANK_W-1:0] bank6(input int c0, input int c1, input int c2,
                                              input int c3, input int c4, input int c5);
    return {COEF_W'(c5), COEF_W'(c4), COEF_W'(c3), COEF_W'(c2), COEF_W'(c1), COEF_W'(c0)};
  endfunction

  function automatic logic [BANK_W-1:0] all6(input int v);
    return bank6(v, v, v, v, v, v);
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; strobes default low each cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    coef_wr_en  = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = ADDR_W'(a);
    coef_wr_data = COEF_W'(d);
  endtask

  int exp_mix [8] = '{60, 60, 70, 80, 90, 100, 110, 120};

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b1;
    in_data      = 16'd5;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    coef_commit  = 1'b0;
    swap_mode    = 1'b0;

    // Reset held with a valid sample offered.
    repeat (3) cyc();
    mid();
    chk("rst_in_ready",  96'(in_ready),  96'(0));
    chk("rst_fir_a",     96'(fir_a),     96'(0));
    chk("rst_fir_coef",  96'(fir_coef),  96'(0));
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_out_tail",  96'(out_tail),  96'(0));
    chk("rst_busy",      96'(busy),      96'(0));
    chk("rst_underrun",  96'(underrun),  96'(0));
    chk("rst_wr_err",    96'(wr_err),    96'(0));

    cyc(); reset = 1'b1; in_data = '0;
    mid(); chk("rel_ready0", 96'(in_ready), 96'(0));
    cyc();
    mid(); chk("rel_ready1", 96'(in_ready), 96'(1));

    // Impulse through bank {1..6} with immediate swap.
    for (int k = 0; k < NTAPS; k++) begin cyc(); wr(k, k + 1); end
    cyc(); coef_commit = 1'b1; swap_mode = 1'b0;
    mid();
    chk("imm_old_bank", 96'(fir_coef), 96'(0));
    chk("imm_busy_c",   96'(busy),     96'(0));
    cyc();
    mid();
    chk("imm_new_bank", 96'(fir_coef), 96'(bank6(1, 2, 3, 4, 5, 6)));
    chk("imm_busy_p",   96'(busy),     96'(1));
    cyc(); in_data = 16'd100;
    mid();
    chk("imm_busy_end", 96'(busy),  96'(0));
    chk("imm_fir_a",    96'(fir_a), 96'(100));
    cyc(); in_data = '0;
    for (int k = 0; k < NTAPS; k++) begin
      cyc(); mid();
      chk("imp_b",     96'(b),         96'(100 * (k + 1)));
      chk("imp_valid", 96'(out_valid), 96'(1));
    end
    cyc(); mid(); chk("imp_b_end", 96'(b), 96'(0));

    // Immediate-swap boundary: ones then twos under a constant 10 stream.
    for (int k = 0; k < NTAPS; k++) begin cyc(); wr(k, 1); end
    cyc(); coef_commit = 1'b1; swap_mode = 1'b0;
    cyc(); in_data = 16'd10;
    cyc();
    for (int k = 0; k < NTAPS; k++) begin cyc(); wr(k, 2); end
    cyc(); coef_commit = 1'b1; swap_mode = 1'b0;
    mid();
    chk("mix_pre_b",    96'(b),        96'(60));
    chk("mix_old_bank", 96'(fir_coef), 96'(all6(1)));
    for (int j = 0; j < 8; j++) begin
      cyc(); mid();
      if (j == 0) chk("mix_new_bank", 96'(fir_coef), 96'(all6(2)));
      chk("mix_b", 96'(b), 96'(exp_mix[j]));
    end

    // Drain swap to threes, with a dropped write and commit during drain.
    for (int k = 0; k < NTAPS; k++) begin cyc(); wr(k, 3); end
    cyc(); coef_commit = 1'b1; swap_mode = 1'b1;
    mid();
    chk("drn_busy0",  96'(busy),     96'(0));
    chk("drn_ready0", 96'(in_ready), 96'(1));
    chk("drn_fir_a0", 96'(fir_a),    96'(10));
    for (int j = 1; j <= 5; j++) begin
      cyc();
      if (j == 1) wr(0, 7);
      if (j == 2) begin coef_commit = 1'b1; swap_mode = 1'b0; end
      mid();
      chk("drn_ready", 96'(in_ready),  96'(0));
      chk("drn_fir_a", 96'(fir_a),     96'(0));
      chk("drn_busy",  96'(busy),      96'(1));
      chk("drn_tail",  96'(out_tail),  96'(j >= 3));
      chk("drn_valid", 96'(out_valid), 96'(j <= 2));
      if (j == 1) chk("drn_wr_err0", 96'(wr_err), 96'(0));
      if (j == 2) chk("drn_wr_err1", 96'(wr_err), 96'(1));
      if (j == 5) chk("drn_old_bank", 96'(fir_coef), 96'(all6(2)));
    end
    cyc(); mid();
    chk("drn_ready_back", 96'(in_ready), 96'(1));
    chk("drn_busy_end",   96'(busy),     96'(0));
    chk("drn_new_bank",   96'(fir_coef), 96'(all6(3)));
    chk("drn_tail6",      96'(out_tail), 96'(1));
    chk("drn_b6",         96'(b),        96'(40));
    cyc(); mid();
    chk("drn_tail7",  96'(out_tail),  96'(1));
    chk("drn_valid7", 96'(out_valid), 96'(0));
    chk("drn_b7",     96'(b),         96'(20));
    cyc(); mid();
    chk("drn_tail8",  96'(out_tail),  96'(0));
    chk("drn_valid8", 96'(out_valid), 96'(1));
    chk("drn_first_new_b", 96'(b), 96'(30));
    cyc(); mid(); chk("drn_b9", 96'(b), 96'(60));
    repeat (4) cyc();
    mid(); chk("drn_b13", 96'(b), 96'(180));

    // Underrun.
    chk("und_clear", 96'(underrun), 96'(0));
    cyc(); in_valid = 1'b0;
    mid();
    chk("und_fir_a", 96'(fir_a),    96'(0));
    chk("und_pre",   96'(underrun), 96'(0));
    cyc(); in_valid = 1'b1;
    mid(); chk("und_set", 96'(underrun), 96'(1));
    cyc();
    mid(); chk("und_sticky", 96'(underrun), 96'(1));

    // Reset in the third drain cycle.
    cyc(); coef_commit = 1'b1; swap_mode = 1'b1;
    mid(); chk("rd_bank_pre", 96'(fir_coef), 96'(all6(3)));
    cyc(); cyc();
    cyc(); reset = 1'b0;
    mid();
    chk("rd_fir_coef", 96'(fir_coef), 96'(0));
    chk("rd_busy",     96'(busy),     96'(0));
    chk("rd_ready",    96'(in_ready), 96'(0));
    chk("rd_wr_err",   96'(wr_err),   96'(0));
    chk("rd_underrun", 96'(underrun), 96'(0));
    cyc(); reset = 1'b1;
    cyc(); mid();
    chk("rd_ready_back", 96'(in_ready), 96'(1));
    chk("rd_busy_back",  96'(busy),     96'(0));
    repeat (5) cyc();
    mid();
    chk("rd_commit_lost", 96'(fir_coef), 96'(0));
    chk("rd_busy_idle",   96'(busy),     96'(0));
    cyc(); coef_commit = 1'b1; swap_mode = 1'b0;
    cyc(); mid(); chk("rd_shadow_clear", 96'(fir_coef), 96'(0));

    // Out-of-range tap address.
    cyc(); wr(6, 9);
    mid(); chk("addr6_pre", 96'(wr_err), 96'(0));
    cyc(); mid(); chk("addr6_err", 96'(wr_err), 96'(1));

    // Write and commit in the same cycle.
    cyc(); wr(2, 5); coef_commit = 1'b1; swap_mode = 1'b0;
    cyc(); mid(); chk("wr_commit_same", 96'(fir_coef), 96'(bank6(0, 0, 5, 0, 0, 0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
